// File: rtl/clk_period_meter_if.sv
// Signal bundle between a slow square-wave source and the period meter.
// The source (master) drives Sig_in; the meter (slave) returns the measurements.
interface clk_period_meter_if #(
  parameter int CNT_W = 25
);
  logic             Sig_in;
  logic [CNT_W-1:0] Period;
  logic [CNT_W-1:0] High_time;
  logic             Period_valid;
  logic             Stalled;

  modport master (
    output Sig_in,
    input  Period, High_time, Period_valid, Stalled
  );

  modport slave (
    input  Sig_in,
    output Period, High_time, Period_valid, Stalled
  );
endinterface

// File: rtl/clk_period_meter.sv
// Measures rise-to-rise period and high time of a slow input in Clk cycles,
// and flags a stall when no rising edge arrives within TIMEOUT cycles.
module clk_period_meter #(
  parameter int               CNT_W   = 25,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(25_000_000)
) (
  input  logic                Clk,
  input  logic                Reset,
  clk_period_meter_if.slave   bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state_reg, state_next;
  logic             s1_reg, s2_reg, p_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] hi_cap_reg, hi_cap_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] high_time_reg, high_time_next;
  logic             valid_reg, valid_next;
  logic             stalled_reg, stalled_next;

  logic             rise, fall;
  logic [CNT_W-1:0] cnt_plus1;

  assign rise      = s2_reg & ~p_reg;
  assign fall      = ~s2_reg & p_reg;
  assign cnt_plus1 = cnt_reg + ONE;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_reg        <= 1'b0;
      s2_reg        <= 1'b0;
      p_reg         <= 1'b0;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      hi_cap_reg    <= '0;
      period_reg    <= '0;
      high_time_reg <= '0;
      valid_reg     <= 1'b0;
      stalled_reg   <= 1'b0;
    end else begin
      s1_reg        <= bus.Sig_in;
      s2_reg        <= s1_reg;
      p_reg         <= s2_reg;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      hi_cap_reg    <= hi_cap_next;
      period_reg    <= period_next;
      high_time_reg <= high_time_next;
      valid_reg     <= valid_next;
      stalled_reg   <= stalled_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    hi_cap_next    = hi_cap_reg;
    period_next    = period_reg;
    high_time_next = high_time_reg;
    valid_next     = 1'b0;
    stalled_next   = stalled_reg;

    case (state_reg)
      IDLE: begin
        // The first edge only arms the meter; there is no previous rise to measure from.
        if (rise) begin
          cnt_next     = '0;
          hi_cap_next  = '0;
          stalled_next = 1'b0;
          state_next   = MEASURE;
        end
      end
      MEASURE: begin
        cnt_next = cnt_plus1;
        if (fall) begin
          hi_cap_next = cnt_plus1;
        end
        // A rise on the timeout cycle still counts as a valid period of TIMEOUT.
        if (rise) begin
          period_next    = cnt_plus1;
          high_time_next = hi_cap_reg;
          valid_next     = 1'b1;
          cnt_next       = '0;
          hi_cap_next    = '0;
        end else if (cnt_reg == TIMEOUT - ONE) begin
          state_next     = IDLE;
          stalled_next   = 1'b1;
          period_next    = '0;
          high_time_next = '0;
          cnt_next       = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.Period       = period_reg;
  assign bus.High_time    = high_time_reg;
  assign bus.Period_valid = valid_reg;
  assign bus.Stalled      = stalled_reg;

endmodule
